sync_sram_clr: RTL and testbench
================================

// Module: sync_sram_clr
// PURPOSE
//   Parametrised single-port synchronous SRAM with lane-masked writes, registered reads,
//   and a hardware clear engine that zero-fills the whole array after reset or on request.
//   Keeps the existing CS/RW_en access semantics (active-low chip select, RW_en=1 read).
//   Intended as the general on-chip scratch/buffer memory for sequential blocks.
// PARAMETERS
//   DATA_W   8              word width in bits; must be a multiple of LANE_W
//   LANE_W   8              write-mask lane width in bits
//   ADDR_W   6              address width
//   DEPTH    (1<<ADDR_W)    number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
// PORTS
//   clk        in   1                clock; all state updates on the rising edge
//   rst        in   1                synchronous, active-high reset
//   CS         in   1                chip select, active low
//   RW_en      in   1                1 = read, 0 = write (sampled when CS=0)
//   Address    in   ADDR_W           word address
//   Data_in    in   DATA_W           write data
//   Wr_mask    in   DATA_W/LANE_W    per-lane write enable, 1 = lane written
//   Clr_req    in   1                one-cycle request to zero-fill the whole array
//   Data_out   out  DATA_W           read data, registered
//   Rd_valid   out  1                1-cycle pulse: Data_out holds new read data
//   Busy       out  1                1 while the clear engine runs; accesses are ignored
// BEHAVIOUR
//   Reset (rst=1 at an edge): Data_out=0, Rd_valid=0, Busy=1, clr_ptr=0, state=CLEAR.
//     Array contents are not reset directly; the clear engine zeroes them.
//   FSM: CLEAR, IDLE.
//     CLEAR: each cycle writes 0 to word clr_ptr, then clr_ptr++. The cycle that writes
//       DEPTH-1 moves to IDLE. Busy=1 throughout, so the first access is accepted
//       exactly DEPTH cycles after rst deasserts. CS, RW_en and Clr_req are ignored.
//     IDLE: Busy=0. Clr_req=1 -> CLEAR with clr_ptr=0; Busy rises the next cycle.
//       An access presented in the same cycle as Clr_req still executes.
//   Access (IDLE, CS=0):
//     read  (RW_en=1): Data_out <= mem[Address] at this edge; Rd_valid=1 for one cycle
//       (1-cycle latency). Back-to-back reads give one result per cycle.
//     write (RW_en=0): for each lane i with Wr_mask[i]=1,
//       mem[Address][i*LANE_W +: LANE_W] <= Data_in lane i. Other lanes keep their value.
//       Wr_mask=0 is a legal no-op write. Data_out holds its value; Rd_valid=0.
//   CS=1 or Busy=1: no array change, Rd_valid=0, Data_out holds its last value.
//   Out of range (Address >= DEPTH): write is dropped; read returns Data_out=0 with
//     Rd_valid=1. No wrap-around.
//   Read after write to the same address on the next cycle returns the new data.
//   rst asserted mid-clear or mid-access: the operation is abandoned and the full
//     reset behaviour above applies. A partial clear restarts from word 0.
//   Clr_req while already in CLEAR: ignored; the current sweep is not restarted.
// STRUCTURE
//   Package sync_sram_pkg:
//     - state encoding localparams ST_CLEAR / ST_IDLE
//     - default LANE_W
//     - function lanes(DATA_W, LANE_W) returning the mask width
//   Sub-module sram_core:
//     - storage array, one write port with lane mask, registered read port
//     - no reset on the array, so it can infer block RAM
//   Top level sync_sram_clr:
//     - FSM and clr_ptr
//     - muxes the clear-engine write (all-lanes mask, zero data) ahead of the user port
//     - range check, Rd_valid and Busy generation
//   Elaboration checks: DATA_W % LANE_W == 0 and DEPTH <= 2**ADDR_W, else $error.
// TESTING
//   1. Reset then wait: rst=1 for 2 cycles, release. Busy=1 for exactly 64 cycles,
//      then 0. Reading any address gives 8'h00 with Rd_valid=1 one cycle later.
//   2. Write then read: write 8'hA5 to addr 6'h2A, read 6'h2A next cycle ->
//      Data_out=8'hA5 and Rd_valid pulses one cycle after the read.
//   3. Lane mask (DATA_W=32): write 32'hDEADBEEF with mask 4'b1111, then 32'h11223344
//      with mask 4'b0101 -> readback 32'hDE22BE44.
//   4. Clr_req while IDLE: issue Clr_req after filled data. Accesses during Busy have
//      no effect and give no Rd_valid. After the clear, every word reads 0.
//   5. Reset during clear: assert rst at clr_ptr=30. Busy stays high and the sweep
//      restarts; Busy falls 64 cycles after the rst release.
//   6. Boundaries (DEPTH=40, ADDR_W=6): a write to addr 45 is dropped; a read of addr 45
//      gives 0 with Rd_valid=1. CS=1 with RW_en=1 gives no Rd_valid and Data_out holds.

Source files
------------

// File: rtl/sync_sram_clr_pkg.sv
// Shared types and helpers for the clearable single-port SRAM.
package sync_sram_pkg;

  localparam int unsigned DEFAULT_LANE_W = 8;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_IDLE  = 1'b1;

  typedef enum logic {
    StClear = ST_CLEAR,
    StIdle  = ST_IDLE
  } state_e;

  function automatic int unsigned lanes(int unsigned data_w, int unsigned lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/sync_sram_clr_if.sv
// Access bus of the clearable SRAM: requester drives master, memory implements slave.
interface sync_sram_clr_if
  import sync_sram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANE_W = DEFAULT_LANE_W,
  parameter int unsigned ADDR_W = 6
);

  logic                                 CS;
  logic                                 RW_en;
  logic [ADDR_W-1:0]                    Address;
  logic [DATA_W-1:0]                    Data_in;
  logic [lanes(DATA_W, LANE_W)-1:0]     Wr_mask;
  logic                                 Clr_req;
  logic [DATA_W-1:0]                    Data_out;
  logic                                 Rd_valid;
  logic                                 Busy;

  modport master (
    output CS, RW_en, Address, Data_in, Wr_mask, Clr_req,
    input  Data_out, Rd_valid, Busy
  );

  modport slave (
    input  CS, RW_en, Address, Data_in, Wr_mask, Clr_req,
    output Data_out, Rd_valid, Busy
  );

endinterface

// File: rtl/sync_sram_clr_sram_core.sv
// Storage array with one lane-masked write port and a registered read port.
// No reset on the array or read register so the tools can map it to block RAM.
module sram_core
  import sync_sram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANE_W = DEFAULT_LANE_W,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic                             re,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [DATA_W-1:0]                wdata,
  input  logic [lanes(DATA_W, LANE_W)-1:0] wmask,
  output logic [DATA_W-1:0]                rdata
);

  localparam int unsigned MaskW = lanes(DATA_W, LANE_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < MaskW; i++) begin
        if (wmask[i]) begin
          mem_q[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_sram_clr.sv
// Single-port SRAM with lane-masked writes, registered reads and a zero-fill clear engine
// that sweeps the whole array after reset or on Clr_req.
module sync_sram_clr
  import sync_sram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANE_W = DEFAULT_LANE_W,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = (1 << ADDR_W)
) (
  input logic             clk,
  input logic             rst,
  sync_sram_clr_if.slave  bus
);

  localparam int unsigned       MaskW   = lanes(DATA_W, LANE_W);
  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  if (DATA_W % LANE_W != 0) begin : g_lane_err
    $error("sync_sram_clr: DATA_W must be a multiple of LANE_W");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_err
    $error("sync_sram_clr: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
  end

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              busy_q;
  logic              rd_valid_q;
  logic              zero_q;

  logic              in_range;
  logic              acc_rd;
  logic              acc_wr;
  logic              clearing;
  logic              core_we;
  logic              core_re;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [MaskW-1:0]  core_wmask;
  logic [DATA_W-1:0] core_rdata;

  always_comb begin
    clearing = (state_q == StClear);
    in_range = ({1'b0, bus.Address} < DepthW);
    acc_rd   = !rst && (state_q == StIdle) && !bus.CS && bus.RW_en;
    acc_wr   = !rst && (state_q == StIdle) && !bus.CS && !bus.RW_en && in_range;

    // The sweep owns the port while clearing; user accesses only land in StIdle.
    core_we    = (!rst && clearing) || acc_wr;
    core_re    = acc_rd && in_range;
    core_addr  = clearing ? clr_ptr_q : bus.Address;
    core_wdata = clearing ? '0 : bus.Data_in;
    core_wmask = clearing ? '1 : bus.Wr_mask;
  end

  sram_core #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .re    (core_re),
    .addr  (core_addr),
    .wdata (core_wdata),
    .wmask (core_wmask),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_ptr_q  <= '0;
      busy_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      rd_valid_q <= acc_rd;
      // zero_q masks the un-reset core read register after reset and on out-of-range reads.
      if (acc_rd) begin
        zero_q <= !in_range;
      end
      unique case (state_q)
        StClear: begin
          clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == LastPtr) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StIdle: begin
          if (bus.Clr_req) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= StClear;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Data_out = zero_q ? '0 : core_rdata;
  assign bus.Rd_valid = rd_valid_q;
  assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_sync_sram_clr.sv
// Bench for sync_sram_clr: a 32-bit/64-word instance checked against a word-array model,
// plus an 8-bit/40-word instance exercising the address boundary from a vector table.
module tb_sync_sram_clr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_sram_clr_if #(.DATA_W(32), .LANE_W(8), .ADDR_W(6)) ifa ();
  sync_sram_clr_if #(.DATA_W(8),  .LANE_W(8), .ADDR_W(6)) ifb ();

  sync_sram_clr #(.DATA_W(32), .LANE_W(8), .ADDR_W(6), .DEPTH(64)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  sync_sram_clr #(.DATA_W(8), .LANE_W(8), .ADDR_W(6), .DEPTH(40)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int errors = 0;
  int checks = 0;

  // Reference model for instance A: word array plus remaining clear cycles.
  logic [31:0] mdl_mem [64];
  int          mdl_rem = 64;
  logic [31:0] mdl_dout = '0;
  logic        mdl_rdv = 1'b0;

  typedef struct {
    logic       cs;
    logic       rw;
    logic [5:0] addr;
    logic [7:0] din;
    logic       mask;
    logic [7:0] exp_dout;
    logic       exp_rdv;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      mdl_rem  = 64;
      mdl_rdv  = 1'b0;
      mdl_dout = '0;
    end else if (mdl_rem > 0) begin
      mdl_rem--;
      mdl_rdv = 1'b0;
      if (mdl_rem == 0) begin
        foreach (mdl_mem[i]) mdl_mem[i] = '0;
      end
    end else begin
      mdl_rdv = 1'b0;
      if (!ifa.CS) begin
        if (ifa.RW_en) begin
          mdl_rdv  = 1'b1;
          mdl_dout = mdl_mem[ifa.Address];
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (ifa.Wr_mask[i]) mdl_mem[ifa.Address][8*i +: 8] = ifa.Data_in[8*i +: 8];
          end
        end
      end
      if (ifa.Clr_req) mdl_rem = 64;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("a_busy", {31'b0, ifa.Busy}, {31'b0, mdl_rem > 0});
    chk("a_rd_valid", {31'b0, ifa.Rd_valid}, {31'b0, mdl_rdv});
    chk("a_data_out", ifa.Data_out, mdl_dout);
  endtask

  task automatic idle_a();
    ifa.CS = 1'b1; ifa.RW_en = 1'b1; ifa.Address = '0; ifa.Data_in = '0;
    ifa.Wr_mask = '0; ifa.Clr_req = 1'b0;
  endtask

  task automatic idle_b();
    ifb.CS = 1'b1; ifb.RW_en = 1'b1; ifb.Address = '0; ifb.Data_in = '0;
    ifb.Wr_mask = '0; ifb.Clr_req = 1'b0;
  endtask

  task automatic acc_a(input logic rw, input logic [5:0] addr, input logic [31:0] din,
                       input logic [3:0] mask);
    ifa.CS = 1'b0; ifa.RW_en = rw; ifa.Address = addr; ifa.Data_in = din;
    ifa.Wr_mask = mask; ifa.Clr_req = 1'b0;
  endtask

  // Counts cycles from now until Busy on A reads low; returns -1 if the bound runs out.
  task automatic busy_len(output int cnt, output int fall_b);
    cnt    = 0;
    fall_b = -1;
    for (int k = 0; k < 200; k++) begin
      cycle();
      cnt++;
      if (!ifb.Busy && fall_b < 0) fall_b = cnt;
      if (!ifa.Busy) return;
    end
    cnt = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int fall_b;

    tbl[0]  = '{1'b0, 1'b0, 6'd5,  8'hA5, 1'b1, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 6'd5,  8'h00, 1'b0, 8'hA5, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 6'd45, 8'h3C, 1'b1, 8'hA5, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 6'd45, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 6'd5,  8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 6'd39, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 6'd39, 8'hFF, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 6'd39, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 6'd39, 8'hC3, 1'b1, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 6'd39, 8'h00, 1'b0, 8'hC3, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 6'd40, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 6'd5,  8'h77, 1'b1, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 6'd5,  8'h00, 1'b0, 8'hA5, 1'b1};

    idle_a();
    idle_b();

    // Reset for two cycles, then the power-up sweep.
    rst = 1'b1;
    cycle();
    cycle();
    chk("reset_data_out", ifa.Data_out, 32'h0);
    chk("reset_busy", {31'b0, ifa.Busy}, 32'h1);
    rst = 1'b0;
    busy_len(cnt, fall_b);
    chk("init_busy_len_a", cnt, 64);
    chk("init_busy_len_b", fall_b, 40);

    for (int a = 0; a < 64; a++) begin
      acc_a(1'b1, 6'(a), 32'h0, 4'h0);
      cycle();
      chk("init_read_zero", ifa.Data_out, 32'h0);
    end
    idle_a();
    cycle();

    // Write then read the same address.
    acc_a(1'b0, 6'h2A, 32'h0000_00A5, 4'hF);
    cycle();
    acc_a(1'b1, 6'h2A, 32'h0, 4'h0);
    cycle();
    chk("wr_rd_data", ifa.Data_out, 32'h0000_00A5);
    chk("wr_rd_valid", {31'b0, ifa.Rd_valid}, 32'h1);
    idle_a();
    cycle();
    chk("rd_valid_pulse", {31'b0, ifa.Rd_valid}, 32'h0);

    // Lane-masked overwrite.
    acc_a(1'b0, 6'h10, 32'hDEAD_BEEF, 4'b1111);
    cycle();
    acc_a(1'b0, 6'h10, 32'h1122_3344, 4'b0101);
    cycle();
    acc_a(1'b1, 6'h10, 32'h0, 4'h0);
    cycle();
    chk("lane_mask", ifa.Data_out, 32'hDE22_BE44);

    // Boundary table on instance B while A sits idle.
    idle_a();
    for (int v = 0; v < 13; v++) begin
      ifb.CS = tbl[v].cs; ifb.RW_en = tbl[v].rw; ifb.Address = tbl[v].addr;
      ifb.Data_in = tbl[v].din; ifb.Wr_mask = tbl[v].mask; ifb.Clr_req = 1'b0;
      cycle();
      chk($sformatf("tbl%0d_dout", v), {24'b0, ifb.Data_out}, {24'b0, tbl[v].exp_dout});
      chk($sformatf("tbl%0d_rdv", v), {31'b0, ifb.Rd_valid}, {31'b0, tbl[v].exp_rdv});
    end
    idle_b();

    // Fill, then Clr_req together with a write that must still land before the sweep.
    for (int a = 0; a < 64; a++) begin
      acc_a(1'b0, 6'(a), $urandom, 4'hF);
      cycle();
    end
    acc_a(1'b0, 6'd3, 32'h7777_7777, 4'hF);
    ifa.Clr_req = 1'b1;
    cycle();
    chk("clr_busy_rise", {31'b0, ifa.Busy}, 32'h1);
    for (int k = 0; k < 20; k++) begin
      acc_a(k[0], 6'(k), 32'hFFFF_FFFF, 4'hF);
      cycle();
      chk("busy_no_rdv", {31'b0, ifa.Rd_valid}, 32'h0);
    end
    idle_a();
    busy_len(cnt, fall_b);
    chk("clr_busy_len", cnt, 44);
    for (int a = 0; a < 64; a++) begin
      acc_a(1'b1, 6'(a), 32'h0, 4'h0);
      cycle();
      chk("clr_read_zero", ifa.Data_out, 32'h0);
    end

    // Reset while the sweep is at word 30: sweep restarts from 0.
    idle_a();
    ifa.Clr_req = 1'b1;
    cycle();
    idle_a();
    for (int k = 0; k < 30; k++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    busy_len(cnt, fall_b);
    chk("rst_mid_clear_len", cnt, 64);

    // Randomized traffic against the model, including occasional clears and resets.
    for (int k = 0; k < 600; k++) begin
      ifa.CS      = ($urandom_range(0, 3) == 0);
      ifa.RW_en   = $urandom_range(0, 1) == 1;
      ifa.Address = 6'($urandom);
      ifa.Data_in = $urandom;
      ifa.Wr_mask = 4'($urandom);
      ifa.Clr_req = ($urandom_range(0, 79) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_a();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
